instr_fetch: RTL
================

# instr_fetch

Front-end fetch stage of the core. It holds the fetch PC and assembles each 32-bit instruction from four byte reads over the byte-wide instruction memory port. Completed instructions are buffered in a small queue and presented, with their PC, to the execute stage. It consumes the execute stage's `ready` and `pc_change`/`new_pc` outputs to pop instructions and redirect fetch.

## Interface
Parameters:
- `RESET_PC`, 32'h0: fetch PC loaded on reset.
- `QUEUE_DEPTH`, 2: instruction queue entries; power of two, ≥2.

Ports:
- `i_clk`: in, 1. Clock.
- `i_rst`: in, 1. Reset: synchronous, active-high; clock `i_clk`.
- `o_imem_addr`: out, 32. Byte address of the current read.
- `o_imem_rd`: out, 1. Read strobe; address is valid when high.
- `i_imem_data`: in, 8. Byte at `o_imem_addr`, combinational same-cycle read; sampled at the rising edge.
- `o_inst`: out, 32. Queue head instruction, or the `NOP` encoding when the queue is empty.
- `o_pc`: out, 32. PC of the queue head; 0 when empty.
- `o_valid`: out, 1. Queue non-empty.
- `i_ready`: in, 1. Execute is in the last cycle of the presented instruction.
- `i_pc_change`: in, 1. Execute requests a redirect.
- `i_new_pc`: in, 32. Redirect target.
- `o_halt`: out, 1. Sticky flag for a misaligned redirect; fetch is stopped.

## Operation
- **Pop:** a pop occurs at an edge where `o_valid && i_ready`. `i_pc_change` is honoured only at a pop edge; otherwise it is ignored.
- **States:**
  - `FETCH`: 2-bit byte counter `cnt`. `o_imem_addr = fetch_pc + cnt`, `o_imem_rd = 1`.
    - Each edge shifts `i_imem_data` into a 32-bit assembly register, most-significant byte first: the byte at `fetch_pc` lands in bits 31:24, matching the core's load byte order.
    - `cnt` increments and wraps 3→0.
  - Byte-3 edge in `FETCH`:
    - If the queue has space (`count < QUEUE_DEPTH`, or a pop at the same edge), push {word, `fetch_pc`}, set `fetch_pc += 4`, stay in `FETCH`.
    - Otherwise go to `WAIT_SPACE`, holding the word.
  - `WAIT_SPACE`: `o_imem_rd = 0`, `o_imem_addr = fetch_pc`. At the first edge with space (including a pop at the same edge), push, set `fetch_pc += 4`, and go to `FETCH` with `cnt = 0`.
  - `HALT`: `o_imem_rd = 0`. No pushes. The queue keeps draining normally. Exit only by reset.
- **Redirect** (honoured `i_pc_change`) has priority over everything:
  - Flush the queue, including an entry being pushed at the same edge.
  - Discard the partial word.
  - Set `cnt = 0`, `fetch_pc = i_new_pc`, state `FETCH`.
  - If `i_new_pc[1:0] != 0`, go to `HALT` instead and set `o_halt`.
- `fetch_pc + 4` and `fetch_pc + cnt` wrap modulo 2^32.
- Push and pop at the same edge on a full queue are legal; count is unchanged.

## Timing
- **Reset values:** state `FETCH`, `cnt = 0`, `fetch_pc = RESET_PC`, queue empty.
- **Outputs in the reset state:** `o_imem_addr = RESET_PC`, `o_imem_rd = 1`, `o_valid = 0`, `o_inst = NOP`, `o_pc = 0`, `o_halt = 0`.
- Reset mid-fetch or mid-`WAIT_SPACE` discards everything; no push occurs at the reset edge.
- **Latency:** the first instruction is visible (`o_valid = 1`) after the 4th edge following reset deassertion. Steady state is one instruction per 4 cycles.
- **Redirect penalty:** after a redirect edge, `o_valid = 0` (`NOP` presented) for 4 cycles. The target instruction is visible after the 4th edge.
- `o_inst`, `o_pc`, and `o_valid` are registered queue-head values; no combinational path from `i_imem_data`.
- `o_imem_addr` and `o_imem_rd` depend only on registered state.

## Structure
- `common.svh` additions:
  - `NOP` instruction encoding (32-bit, using the existing `NOP` opcode).
  - Fetch state encoding `FETCH`/`WAIT_SPACE`/`HALT`.
  - `INST_WIDTH` = 32.
- Sub-module `instr_queue`: synchronous FIFO of {inst, pc}, `QUEUE_DEPTH` entries, with push/pop/flush, `count`, and head outputs. Flush overrides push. Wrap-around read/write pointers.
- `instr_fetch`: FSM, byte counter, assembly register, and redirect logic.

## Test plan
- **Reset fetch:** reset with `RESET_PC=0` and memory bytes 00 00 00 13 at 0..3, `i_ready=0` → addresses 0,1,2,3 on consecutive cycles; after the 4th edge, `o_valid=1`, `o_inst=32'h00000013`, `o_pc=0`.
- **Queue fill:** hold `i_ready=0` through 12 cycles → queue holds PCs 0 and 4; state `WAIT_SPACE` with the PC 8 word held and `o_imem_rd=0`. Pulse `i_ready` → head becomes PC 4, the PC 8 word is pushed at the same edge, and fetch resumes at address 12.
- **Redirect:** `i_ready=1` with `i_pc_change=1`, `i_new_pc=32'h100`, and the queue full → `o_valid=0` for 4 cycles, addresses 0x100..0x103, then `o_pc=32'h100`.
- **Ignored redirect:** `i_pc_change=1` while `i_ready=0` → no flush and no change to the fetch address.
- **Misaligned redirect:** `i_new_pc=32'h102` at a pop edge → `o_halt=1` the next cycle, `o_imem_rd=0`, queue empty, held until `i_rst`.
- **Address wrap:** `RESET_PC=32'hFFFFFFFC` → reads FFFFFFFC..FFFFFFFF, then the next fetch starts at address 0.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared constants and types for the fetch stage
// Contents: INST_WIDTH, NOP encoding, fetch FSM state encoding.
package instr_fetch_pkg;

  localparam int INST_WIDTH = 32;

  // OP-IMM opcode; addi x0, x0, 0 is the canonical no-op.
  localparam logic [6:0]            OPC_NOP = 7'b0010011;
  localparam logic [INST_WIDTH-1:0] NOP     = {25'd0, OPC_NOP};

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    WAIT_SPACE = 2'd1,
    HALT       = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - synchronous FIFO of {inst, pc} pairs
// Ports: i_clk, i_rst (sync, active-high); push/push_inst/push_pc write side;
// pop read side; flush empties the queue and wins over push;
// count, valid, head_inst (NOP when empty), head_pc (0 when empty).
module instr_queue
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  push,
  input  logic [INST_WIDTH-1:0] push_inst,
  input  logic [31:0]           push_pc,
  input  logic                  pop,
  input  logic                  flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                  valid,
  output logic [INST_WIDTH-1:0] head_inst,
  output logic [31:0]           head_pc
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
  logic [31:0]           pc_mem   [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !flush && !i_rst) begin
      inst_mem[wr_ptr] <= push_inst;
      pc_mem[wr_ptr]   <= push_pc;
    end
  end

  assign valid     = (count != '0);
  assign head_inst = valid ? inst_mem[rd_ptr] : NOP;
  assign head_pc   = valid ? pc_mem[rd_ptr]   : 32'd0;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - byte-serial instruction fetch with instruction queue
// Ports: i_clk, i_rst (sync, active-high); o_imem_addr/o_imem_rd/i_imem_data
// byte memory port; o_inst/o_pc/o_valid queue head to execute; i_ready pops;
// i_pc_change/i_new_pc redirect at a pop edge; o_halt sticky misalignment flag.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  output logic [31:0]           o_imem_addr,
  output logic                  o_imem_rd,
  input  logic [7:0]            i_imem_data,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [31:0]           o_pc,
  output logic                  o_valid,
  input  logic                  i_ready,
  input  logic                  i_pc_change,
  input  logic [31:0]           i_new_pc,
  output logic                  o_halt
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = QUEUE_DEPTH[CNT_W-1:0];

  fetch_state_e          state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [31:0]           fetch_pc_q, fetch_pc_d;
  logic [INST_WIDTH-1:0] asm_q, asm_d;

  logic                  push;
  logic [INST_WIDTH-1:0] push_inst;
  logic [CNT_W-1:0]      q_count;
  logic                  pop;
  logic                  redirect;
  logic                  space;

  assign pop      = o_valid && i_ready;
  // HALT is left only by reset; the queue is already empty there anyway.
  assign redirect = pop && i_pc_change && (state_q != HALT);
  // A pop at the same edge frees the slot the push needs.
  assign space    = (q_count < DEPTH_CNT) || pop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= FETCH;
      cnt_q      <= 2'd0;
      fetch_pc_q <= RESET_PC;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fetch_pc_q <= fetch_pc_d;
      asm_q      <= asm_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fetch_pc_d = fetch_pc_q;
    asm_d      = asm_q;
    push       = 1'b0;
    push_inst  = asm_q;

    case (state_q)
      FETCH: begin
        // Most-significant byte first: byte at fetch_pc ends in [31:24].
        asm_d = {asm_q[23:0], i_imem_data};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          if (space) begin
            push       = 1'b1;
            push_inst  = asm_d;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else begin
            state_d = WAIT_SPACE;
          end
        end
      end
      WAIT_SPACE: begin
        if (space) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          cnt_d      = 2'd0;
          state_d    = FETCH;
        end
      end
      HALT: begin
      end
      default: state_d = FETCH;
    endcase

    if (redirect) begin
      push       = 1'b0;
      asm_d      = '0;
      cnt_d      = 2'd0;
      fetch_pc_d = i_new_pc;
      state_d    = (i_new_pc[1:0] != 2'b00) ? HALT : FETCH;
    end
  end

  always_comb begin
    o_imem_rd   = 1'b0;
    o_imem_addr = fetch_pc_q;
    if (state_q == FETCH) begin
      o_imem_rd   = 1'b1;
      o_imem_addr = fetch_pc_q + {30'd0, cnt_q};
    end
  end

  assign o_halt = (state_q == HALT);

  instr_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .push     (push),
    .push_inst(push_inst),
    .push_pc  (fetch_pc_q),
    .pop      (pop),
    .flush    (redirect),
    .count    (q_count),
    .valid    (o_valid),
    .head_inst(o_inst),
    .head_pc  (o_pc)
  );

endmodule
